dot_job_sched: RTL and testbench

//   Round-robin scheduler sharing one serial dot-product engine among N_REQ requesters.

---
 rtl/dot_job_sched_if.sv | 33 +++
 rtl/dot_job_sched.sv | 121 ++++++++++++
 tb/tb_dot_job_sched.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dot_job_sched_if.sv
// Requester, result and engine-side signals shared by dot_job_sched and its environment.
// The scheduler uses the master modport; requesters, consumer and engine sit on the slave side.
interface dot_job_sched_if #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned DIN_W  = 8,
    parameter int unsigned DOUT_W = 18
);
    localparam int unsigned ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]         req_valid;
    logic [N_REQ*6*DIN_W-1:0] req_data;
    logic [N_REQ-1:0]         req_ack;
    logic                     res_valid;
    logic                     res_ready;
    logic [DOUT_W-1:0]        res_data;
    logic [ID_W-1:0]          res_id;
    logic                     res_err;
    logic                     busy;
    logic                     eng_resetn;
    logic [DIN_W-1:0]         eng_din;
    logic [DOUT_W-1:0]        eng_dout;
    logic                     eng_run;

    modport master (
        input  req_valid, req_data, res_ready, eng_dout, eng_run,
        output req_ack, res_valid, res_data, res_id, res_err, busy, eng_resetn, eng_din
    );

    modport slave (
        output req_valid, req_data, res_ready, eng_dout, eng_run,
        input  req_ack, res_valid, res_data, res_id, res_err, busy, eng_resetn, eng_din
    );
endinterface

// File: rtl/dot_job_sched.sv
// Round-robin scheduler sharing one serial dot-product engine among N_REQ requesters.
// Each job: grant + latch, stream 6 operand bytes, capture the result, hold it until consumed.
module dot_job_sched #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned DIN_W  = 8,
    parameter int unsigned DOUT_W = 18
) (
    input logic              clk,
    input logic              reset,
    dot_job_sched_if.master  bus
);
    localparam int unsigned ID_W  = $clog2(N_REQ);
    localparam int unsigned OPS_W = 6 * DIN_W;

    typedef enum logic [1:0] {StIdle, StFeed, StCapt, StResp} state_e;

    state_e            state_q, state_d;
    logic [ID_W-1:0]   rr_q, rr_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [OPS_W-1:0]  ops_q, ops_d;
    logic [DOUT_W-1:0] res_data_q, res_data_d;
    logic [ID_W-1:0]   res_id_q, res_id_d;
    logic              res_err_q, res_err_d;

    logic              gnt_vld;
    logic [ID_W-1:0]   gnt_idx;
    int unsigned       cand;

    // Walk offsets from far to near so the nearest requester after rr_q wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = 0;
        for (int off = int'(N_REQ); off >= 1; off--) begin
            cand = (32'(rr_q) + 32'(off)) % N_REQ;
            if (bus.req_valid[ID_W'(cand)]) begin
                gnt_vld = 1'b1;
                gnt_idx = ID_W'(cand);
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        rr_d           = rr_q;
        id_d           = id_q;
        cnt_d          = cnt_q;
        ops_d          = ops_q;
        res_data_d     = res_data_q;
        res_id_d       = res_id_q;
        res_err_d      = res_err_q;
        bus.req_ack    = '0;
        bus.res_valid  = 1'b0;
        bus.eng_resetn = 1'b0;
        bus.eng_din    = '0;

        unique case (state_q)
            StIdle: begin
                // Ack is masked during reset so every output reads 0 while reset is held.
                if (gnt_vld && !reset) begin
                    bus.req_ack = N_REQ'(1) << gnt_idx;
                    ops_d       = bus.req_data[32'(gnt_idx) * OPS_W +: OPS_W];
                    id_d        = gnt_idx;
                    rr_d        = gnt_idx;
                    cnt_d       = '0;
                    state_d     = StFeed;
                end
            end
            StFeed: begin
                bus.eng_resetn = 1'b1;
                bus.eng_din    = ops_q[32'(cnt_q) * DIN_W +: DIN_W];
                cnt_d          = cnt_q + 3'd1;
                if (cnt_q == 3'd5) begin
                    state_d = StCapt;
                end
            end
            StCapt: begin
                bus.eng_resetn = 1'b1;
                res_data_d     = bus.eng_dout;
                res_err_d      = (bus.eng_run !== 1'b1);
                res_id_d       = id_q;
                state_d        = StResp;
            end
            StResp: begin
                bus.res_valid = 1'b1;
                if (bus.res_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            rr_q       <= ID_W'(N_REQ - 1);
            id_q       <= '0;
            cnt_q      <= '0;
            ops_q      <= '0;
            res_data_q <= '0;
            res_id_q   <= '0;
            res_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            id_q       <= id_d;
            cnt_q      <= cnt_d;
            ops_q      <= ops_d;
            res_data_q <= res_data_d;
            res_id_q   <= res_id_d;
            res_err_q  <= res_err_d;
        end
    end

    assign bus.res_data = res_data_q;
    assign bus.res_id   = res_id_q;
    assign bus.res_err  = res_err_q;
    assign bus.busy     = (state_q != StIdle);
endmodule

// File: tb/tb_dot_job_sched.sv
// Randomised scoreboard bench for dot_job_sched with a behavioural engine and job-level model.
module tb_dot_job_sched;
    localparam int N = 4;

    typedef struct {
        int id;
        int data;
        bit err;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dot_job_sched_if #(.N_REQ(4), .DIN_W(8), .DOUT_W(18)) bus ();

    dot_job_sched #(.N_REQ(4), .DIN_W(8), .DOUT_W(18)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [N-1:0]  pend;
    logic [47:0]   pdata [N];
    logic [N-1:0]  drop_mask;
    int            ready_mode;
    bit            force_next_err;
    bit            rand_err;
    logic          eng_force_err;

    exp_t          exp_q [$];
    int            got_ids [$];
    bit            m_idle;
    int            m_rr;
    int            m_k;
    logic [47:0]   cur_ops;
    int            last_data;
    int            last_id;
    int            last_err;

    assign bus.req_valid = pend;
    for (genvar gi = 0; gi < N; gi++) begin : g_drv
        assign bus.req_data[gi*48 +: 48] = pdata[gi];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] v, input int rr);
        for (int off = 1; off <= N; off++) begin
            if (v[(rr + off) % N]) return (rr + off) % N;
        end
        return -1;
    endfunction

    function automatic int dot(input logic [47:0] d);
        return int'(d[7:0]) * int'(d[31:24]) + int'(d[15:8]) * int'(d[39:32])
             + int'(d[23:16]) * int'(d[47:40]);
    endfunction

    function automatic logic [47:0] pack(input int b0, b1, b2, b3, b4, b5);
        return {8'(b5), 8'(b4), 8'(b3), 8'(b2), 8'(b1), 8'(b0)};
    endfunction

    function automatic logic [7:0] rbyte();
        int r = $urandom_range(0, 7);
        if (r < 2) return 8'hff;
        if (r == 2) return 8'h00;
        return 8'($urandom_range(0, 255));
    endfunction

    // Serial engine: absorbs six bytes while out of reset, then presents a.b with run=1.
    logic [7:0] eb [6];
    int ecnt;
    always @(posedge clk) begin
        if (!bus.eng_resetn) begin
            ecnt         <= 0;
            bus.eng_dout <= '0;
            bus.eng_run  <= 1'b0;
        end else if (ecnt < 6) begin
            eb[ecnt] <= bus.eng_din;
            ecnt     <= ecnt + 1;
            if (ecnt == 5) begin
                bus.eng_dout <= 18'(int'(eb[0]) * int'(eb[3]) + int'(eb[1]) * int'(eb[4])
                                  + int'(eb[2]) * int'(bus.eng_din));
                bus.eng_run  <= !eng_force_err;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        pend      = pend & ~drop_mask;
        drop_mask = '0;
    end

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       bus.res_ready = ($urandom_range(0, 3) != 0);
            1:       bus.res_ready = 1'b1;
            default: bus.res_ready = 1'b0;
        endcase
    end

    // Job-level model: who is granted, job phase timing, and what each job must return.
    always @(negedge clk) begin
        logic [N-1:0] exp_ack;
        int g;
        exp_t e;
        if (reset) begin
            chk("rst_ack", bus.req_ack, 0);
            chk("rst_busy", bus.busy, 0);
            chk("rst_res_valid", bus.res_valid, 0);
            chk("rst_eng_resetn", bus.eng_resetn, 0);
            chk("rst_eng_din", bus.eng_din, 0);
            chk("rst_res_data", {bus.res_id, bus.res_err, bus.res_data}, 0);
        end else begin
            exp_ack = '0;
            g = 0;
            if (m_idle && pend != '0) begin
                g = rr_pick(pend, m_rr);
                exp_ack[g] = 1'b1;
            end
            chk("ack", bus.req_ack, exp_ack);
            chk("busy", bus.busy, !m_idle);
            chk("eng_resetn", bus.eng_resetn, !m_idle && m_k >= 1 && m_k <= 7);
            chk("eng_din", bus.eng_din,
                (!m_idle && m_k >= 1 && m_k <= 6) ? 64'(cur_ops[(m_k-1)*8 +: 8]) : 64'd0);
            chk("res_valid", bus.res_valid, !m_idle && m_k >= 8);
            if (exp_ack != '0) begin
                m_idle  = 1'b0;
                m_k     = 1;
                m_rr    = g;
                cur_ops = pdata[g];
                e.id    = g;
                e.data  = dot(pdata[g]);
                e.err   = force_next_err || (rand_err && $urandom_range(0, 7) == 0);
                force_next_err = 1'b0;
                eng_force_err  = e.err;
                exp_q.push_back(e);
                drop_mask[g] = 1'b1;
            end else if (!m_idle) begin
                if (m_k >= 8 && bus.res_ready) m_idle = 1'b1;
                else m_k++;
            end
        end
    end

    // Result monitor: pops the scoreboard on each transfer and checks held results stay put.
    logic [63:0] hold;
    bit hold_vld;
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            hold_vld = 1'b0;
        end else begin
            if (hold_vld && bus.res_valid)
                chk("res_stable", {bus.res_id, bus.res_err, bus.res_data}, hold);
            if (bus.res_valid && bus.res_ready) begin
                hold_vld = 1'b0;
                if (exp_q.size() == 0) begin
                    chk("res_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("res_id", bus.res_id, e.id);
                    chk("res_data", bus.res_data, e.data);
                    chk("res_err", bus.res_err, e.err);
                    last_id   = int'(bus.res_id);
                    last_data = int'(bus.res_data);
                    last_err  = int'(bus.res_err);
                    got_ids.push_back(int'(bus.res_id));
                end
            end else if (bus.res_valid) begin
                hold_vld = 1'b1;
                hold     = {bus.res_id, bus.res_err, bus.res_data};
            end else begin
                hold_vld = 1'b0;
            end
        end
    end

    task automatic post(input int i, input logic [47:0] d);
        int n = 0;
        while (pend[i] && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("post_timeout", pend[i], 0);
        pdata[i] = d;
        pend[i]  = 1'b1;
    endtask

    task automatic wait_quiet(input int bound);
        int n = 0;
        while (!(pend == '0 && exp_q.size() == 0 && m_idle) && n < bound) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("quiet_timeout", n >= bound, 0);
    endtask

    task automatic assert_reset();
        reset     = 1'b1;
        pend      = '0;
        drop_mask = '0;
        exp_q.delete();
        m_idle = 1'b1;
        m_rr   = N - 1;
        m_k    = 0;
        #1;
        chk("arst_outs", {bus.req_ack, bus.res_valid, bus.busy, bus.eng_resetn, bus.eng_din}, 0);
        chk("arst_res", {bus.res_id, bus.res_err, bus.res_data}, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int n;
        reset = 1'b1;
        pend = '0;
        drop_mask = '0;
        for (int i = 0; i < N; i++) pdata[i] = '0;
        ready_mode = 1;
        bus.res_ready = 1'b1;
        force_next_err = 1'b0;
        rand_err = 1'b0;
        eng_force_err = 1'b0;
        m_idle = 1'b1;
        m_rr = N - 1;
        m_k = 0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // single job
        post(0, pack(1, 2, 3, 4, 5, 6));
        wait_quiet(50);
        chk("t1_data", last_data, 32);
        chk("t1_id", last_id, 0);
        chk("t1_err", last_err, 0);

        // fairness from reset
        @(posedge clk);
        #1;
        assert_reset();
        got_ids.delete();
        for (int i = 0; i < N; i++) post(i, pack(i, i, i, i + 1, i + 1, i + 1));
        post(0, pack(2, 0, 0, 3, 0, 0));
        wait_quiet(200);
        chk("t2_count", got_ids.size(), 5);
        for (int i = 0; i < 5; i++)
            chk("t2_order", (i < got_ids.size()) ? got_ids[i] : -1, i % N);

        // backpressure
        got_ids.delete();
        ready_mode = 2;
        post(3, pack(9, 9, 9, 9, 9, 9));
        n = 0;
        while (!bus.res_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("t3_res_wait", bus.res_valid, 1);
        post(1, pack(1, 1, 1, 1, 1, 1));
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("t3_held", {bus.busy, bus.res_valid, bus.req_ack}, {1'b1, 1'b1, 4'b0000});
        end
        ready_mode = 1;
        wait_quiet(100);
        chk("t3_order", got_ids.size() == 2 && got_ids[0] == 3 && got_ids[1] == 1, 1);
        chk("t3_data", last_data, 3);

        // extreme operands
        post(2, pack(255, 255, 255, 255, 255, 255));
        wait_quiet(50);
        chk("t4_max", last_data, 195075);
        post(1, pack(0, 0, 0, 0, 0, 0));
        wait_quiet(50);
        chk("t4_zero", last_data, 0);
        post(3, pack(7, 8, 9, 1, 2, 3));
        wait_quiet(50);
        chk("t4_mix", last_data, 50);

        // engine run flag missing at capture
        force_next_err = 1'b1;
        post(2, pack(2, 3, 4, 5, 6, 7));
        wait_quiet(50);
        chk("t5_err", last_err, 1);
        chk("t5_data", last_data, 56);
        post(0, pack(1, 0, 0, 1, 0, 0));
        wait_quiet(50);
        chk("t5_recover", {last_err[0], last_data[17:0]}, {1'b0, 18'd1});

        // reset in the middle of feeding
        post(0, pack(5, 5, 5, 5, 5, 5));
        n = 0;
        while (m_idle && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("t6_mid_feed", {bus.busy, bus.eng_din}, {1'b1, 8'd5});
        assert_reset();
        post(2, pack(1, 2, 3, 4, 5, 6));
        wait_quiet(50);
        chk("t6_data", last_data, 32);
        chk("t6_id", last_id, 2);

        // random traffic
        ready_mode = 0;
        rand_err = 1'b1;
        repeat (1500) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 5) == 0) begin
                    pdata[i] = {rbyte(), rbyte(), rbyte(), rbyte(), rbyte(), rbyte()};
                    pend[i]  = 1'b1;
                end else if (pend[i] && $urandom_range(0, 40) == 0) begin
                    pend[i] = 1'b0;
                end
            end
        end
        ready_mode = 1;
        wait_quiet(400);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
